// File: rtl/seq_prime_detector_pkg.sv
// Shared definitions for the sequential prime detector: FSM states, small-prime table, divisor width.
// The SMALL_LUT_EN build option (see seq_prime_detector.sv) consumes SMALL_LUT.
package seq_prime_detector_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_LOOP,
        ST_DIV,
        ST_EVAL
    } state_t;

    // Bit k is set when k is prime: 2, 3, 5, 7, 11, 13.
    localparam logic [15:0] SMALL_LUT = 16'b0010_1000_1010_1100;

    // Odd trial divisors never exceed sqrt(2^width)+2, which fits in width/2+2 bits.
    function automatic int div_width(input int width);
        return width / 2 + 2;
    endfunction

endpackage

// File: rtl/seq_prime_detector_mod_serial.sv
// Serial restoring remainder unit: one dividend bit per cycle, MSB first.
// rdy pulses WIDTH cycles after go; rem holds its value until the next go.
module prime_mod_serial
    import seq_prime_detector_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             go,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             rdy,
    output logic [WIDTH-1:0] rem
);

    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0] q;
    logic [CW-1:0]    cnt;
    logic             active;
    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] next_rem;

    // The go cycle already consumes the dividend MSB, so only WIDTH-1 further steps remain.
    always_comb begin
        trial    = go ? {{WIDTH{1'b0}}, dividend[WIDTH-1]} : {rem, q[WIDTH-1]};
        diff     = trial - {1'b0, divisor};
        next_rem = trial[WIDTH-1:0];
        if (trial >= {1'b0, divisor}) begin
            next_rem = diff[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q      <= '0;
            cnt    <= '0;
            active <= 1'b0;
            rdy    <= 1'b0;
            rem    <= '0;
        end else begin
            rdy <= 1'b0;
            if (go) begin
                rem    <= next_rem;
                q      <= {dividend[WIDTH-2:0], 1'b0};
                cnt    <= CW'(WIDTH - 1);
                active <= 1'b1;
            end else if (active) begin
                rem <= next_rem;
                q   <= {q[WIDTH-2:0], 1'b0};
                cnt <= cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    active <= 1'b0;
                    rdy    <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/seq_prime_detector.sv
// Sequential prime detector: odd trial division of a WIDTH-bit operand with a serial remainder unit.
// Build option SMALL_LUT_EN: resolve every operand below 16 in CHECK from a constant table.
module seq_prime_detector
    import seq_prime_detector_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] n,
    output logic             busy,
    output logic             done,
    output logic             is_prime,
    output logic [WIDTH-1:0] n_out
);

    localparam int DW = div_width(WIDTH);

    state_t           state;
    logic [DW-1:0]    d;
    logic [WIDTH+1:0] dd;
    logic [15:0]      n_ext;
    logic             sq_over;
    logic             go;
    logic             rdy;
    logic [WIDTH-1:0] rem;

    assign dd      = (WIDTH+2)'(d) * (WIDTH+2)'(d);
    assign sq_over = dd > {2'b00, n_out};
    assign n_ext   = 16'(n_out);
    assign go      = (state == ST_LOOP) && !sq_over;

    prime_mod_serial #(.WIDTH(WIDTH)) u_mod (
        .clk      (clk),
        .rst_n    (rst_n),
        .go       (go),
        .dividend (n_out),
        .divisor  (WIDTH'(d)),
        .rdy      (rdy),
        .rem      (rem)
    );

    // Handshake: start is accepted only in IDLE and n is captured on that edge; busy stays high
    // until the finishing edge; done is then high for exactly one cycle with is_prime/n_out valid,
    // and a start in that cycle is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            is_prime <= 1'b0;
            n_out    <= '0;
            d        <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        n_out    <= n;
                        busy     <= 1'b1;
                        is_prime <= 1'b0;
                        state    <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
`ifdef SMALL_LUT_EN
                    if (n_ext < 16'd16) begin
                        is_prime <= SMALL_LUT[n_ext[3:0]];
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        state    <= ST_IDLE;
                    end else
`endif
                    if (n_ext < 16'd2) begin
                        is_prime <= 1'b0;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        state    <= ST_IDLE;
                    end else if (n_ext == 16'd2 || n_ext == 16'd3) begin
                        is_prime <= 1'b1;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        state    <= ST_IDLE;
                    end else if (!n_out[0]) begin
                        is_prime <= 1'b0;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        state    <= ST_IDLE;
                    end else begin
                        d     <= DW'(3);
                        state <= ST_LOOP;
                    end
                end
                ST_LOOP: begin
                    if (sq_over) begin
                        is_prime <= 1'b1;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        state    <= ST_IDLE;
                    end else begin
                        state <= ST_DIV;
                    end
                end
                ST_DIV: begin
                    if (rdy) begin
                        state <= ST_EVAL;
                    end
                end
                ST_EVAL: begin
                    if (rem == '0) begin
                        is_prime <= 1'b0;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        state    <= ST_IDLE;
                    end else begin
                        d     <= d + DW'(2);
                        state <= ST_LOOP;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
